alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 177 +++++++++++++++++
 tb/tb_alu_writeback.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU result writeback stage: holds ALU beats in order, writes the register file and retires status flags.
// Define ALU_WRITEBACK_SKID_EN for a one-entry skid register with a registered in_ready (capacity 2).
module alu_writeback #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] agg,
   input  logic              alu_v,
   input  logic              alu_c,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_x,
   input  logic              set_vc,
   input  logic              set_flags,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic              flush,
   input  logic              rf_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              flag_v,
   output logic              flag_c,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_x
);

   typedef struct packed {
      logic [DATA_W-1:0] agg;
      logic [REG_AW-1:0] wb_addr;
      logic              wb_en;
      logic              set_flags;
      logic              set_vc;
      logic              alu_v;
      logic              alu_c;
      logic              alu_n;
      logic              alu_z;
      logic              alu_x;
   } beat_t;

   typedef struct packed {
      logic v;
      logic c;
      logic n;
      logic z;
      logic x;
   } flags_t;

   beat_t  in_beat;
   beat_t  head_q, head_d;
   logic   head_valid_q, head_valid_d;
   flags_t flags_q, flags_d;
   logic   head_retire;
   logic   accept;

   assign in_beat = '{agg: agg, wb_addr: wb_addr, wb_en: wb_en, set_flags: set_flags,
                      set_vc: set_vc, alu_v: alu_v, alu_c: alu_c, alu_n: alu_n,
                      alu_z: alu_z, alu_x: alu_x};

   // A head that does not write the register file needs no grant to leave.
   assign head_retire = head_valid_q && (rf_ready || !head_q.wb_en);
   assign accept      = in_valid && in_ready && !flush;

`ifdef ALU_WRITEBACK_SKID_EN
   beat_t skid_q, skid_d;
   logic  skid_valid_q, skid_valid_d;
   logic  in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;

   // in_ready_q mirrors !skid_valid_q, so a retire with a full skid never coincides with an accept.
   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
      head_d       = head_q;
      head_valid_d = head_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (head_retire) begin
         if (skid_valid_q) begin
            head_d       = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            head_d       = in_beat;
            head_valid_d = accept;
         end
      end else if (accept) begin
         if (head_valid_q) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
         end else begin
            head_d       = in_beat;
            head_valid_d = 1'b1;
         end
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end
`else
   // Combinational from rf_ready so a retiring head is replaced on the same edge.
   assign in_ready = !head_valid_q || head_retire;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
      head_d       = head_q;
      head_valid_d = head_valid_q;
      if (flush) begin
         head_valid_d = 1'b0;
      end else if (accept) begin
         head_d       = in_beat;
         head_valid_d = 1'b1;
      end else if (head_retire) begin
         head_valid_d = 1'b0;
      end
   end
`endif

   always_comb begin
      flags_d = flags_q;
      if (head_retire && head_q.set_flags && !flush) begin
         flags_d.n = head_q.alu_n;
         flags_d.z = head_q.alu_z;
         flags_d.x = head_q.alu_x;
         if (head_q.set_vc) begin
            flags_d.v = head_q.alu_v;
            flags_d.c = head_q.alu_c;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_valid_q <= 1'b0;
         flags_q      <= '0;
      end else begin
         head_valid_q <= head_valid_d;
         flags_q      <= flags_d;
      end
   end

   // NOTE: beat payload has no reset; it is only observed while its valid bit is set.
   always_ff @(posedge clk) begin
      head_q <= head_d;
   end

   assign rf_we    = head_valid_q && head_q.wb_en;
   assign rf_waddr = head_valid_q ? head_q.wb_addr : '0;
   assign rf_wdata = head_valid_q ? head_q.agg : '0;

   assign flag_v = flags_q.v;
   assign flag_c = flags_q.c;
   assign flag_n = flags_q.n;
   assign flag_z = flags_q.z;
   assign flag_x = flags_q.x;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: single-beat vector table, then back-pressure, flush and reset sequences.
// Expectations hold for both the default build and ALU_WRITEBACK_SKID_EN.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] agg;
   logic        alu_v, alu_c, alu_n, alu_z, alu_x;
   logic        set_vc, set_flags, wb_en;
   logic [3:0]  wb_addr;
   logic        flush;
   logic        rf_ready;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        flag_v, flag_c, flag_n, flag_z, flag_x;

   int passed = 0;
   int total  = 0;

   alu_writeback #(.DATA_W(16), .REG_AW(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .agg(agg),
      .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_x(alu_x),
      .set_vc(set_vc), .set_flags(set_flags), .wb_en(wb_en), .wb_addr(wb_addr),
      .flush(flush), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n),
      .flag_z(flag_z), .flag_x(flag_x)
   );

   always #5 clk = ~clk;

   // Flags are packed {v, c, n, z, x} throughout the bench.
   typedef struct {
      logic [15:0] agg;
      logic [3:0]  addr;
      logic        wb_en;
      logic        set_flags;
      logic        set_vc;
      logic [4:0]  alu_f;
      logic        rf_ready;
      logic        exp_we;
      logic [4:0]  exp_flags;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [15:0] d, input logic [3:0] a, input logic we,
                             input logic sf, input logic svc, input logic [4:0] f);
      in_valid  = 1'b1;
      agg       = d;
      wb_addr   = a;
      wb_en     = we;
      set_flags = sf;
      set_vc    = svc;
      {alu_v, alu_c, alu_n, alu_z, alu_x} = f;
   endtask

   function automatic logic [4:0] cur_flags();
      return {flag_v, flag_c, flag_n, flag_z, flag_x};
   endfunction

   logic [3:0]  bp_addr[3];
   logic [15:0] bp_data[3];
   logic [3:0]  wr_addr[3];
   logic [15:0] wr_data[3];
   int          wr_cyc[3];
   int          idx, n_wr, n_wr5;

   initial begin
      vecs[0] = '{16'h8000, 4'd3,  1'b1, 1'b1, 1'b1, 5'b01100, 1'b1, 1'b1, 5'b01100};
      vecs[1] = '{16'h0000, 4'd7,  1'b1, 1'b1, 1'b0, 5'b10010, 1'b1, 1'b1, 5'b01010};
      vecs[2] = '{16'h1234, 4'd2,  1'b0, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0, 5'b01001};
      vecs[3] = '{16'hffff, 4'd15, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b1, 1'b1, 5'b01001};
      vecs[4] = '{16'h00a5, 4'd9,  1'b1, 1'b1, 1'b1, 5'b10000, 1'b1, 1'b1, 5'b10000};
      vecs[5] = '{16'h7fff, 4'd0,  1'b0, 1'b1, 1'b1, 5'b01111, 1'b0, 1'b0, 5'b01111};
      bp_addr = '{4'd1, 4'd2, 4'd3};
      bp_data = '{16'h00a1, 16'h00b2, 16'h00c3};

      reset = 1'b1;
      flush = 1'b0;
      rf_ready = 1'b0;
      in_valid = 1'b0;
      drive_beat(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 5'b0);
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("reset rf_we", rf_we, 0);
      check("reset rf_waddr", rf_waddr, 0);
      check("reset rf_wdata", rf_wdata, 0);
      check("reset flags", cur_flags(), 0);
      check("reset in_ready", in_ready, 1);

      // Single beats: accept, observe head one cycle later, then flags after the retire edge.
      for (int i = 0; i < 6; i++) begin
         tick();
         drive_beat(vecs[i].agg, vecs[i].addr, vecs[i].wb_en, vecs[i].set_flags,
                    vecs[i].set_vc, vecs[i].alu_f);
         rf_ready = vecs[i].rf_ready;
         @(negedge clk);
         check($sformatf("vec%0d in_ready", i), in_ready, 1);
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d rf_we", i), rf_we, vecs[i].exp_we);
         check($sformatf("vec%0d rf_waddr", i), rf_waddr, vecs[i].addr);
         check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].agg);
         tick();
         @(negedge clk);
         check($sformatf("vec%0d flags", i), cur_flags(), vecs[i].exp_flags);
         check($sformatf("vec%0d retired", i), rf_we, 0);
      end

      // Back-pressure: three beats offered under rf_ready=0, then released.
      idx  = 0;
      n_wr = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         rf_ready = (cyc >= 4);
         if (idx < 3) drive_beat(bp_data[idx], bp_addr[idx], 1'b1, 1'b0, 1'b0, 5'b0);
         else in_valid = 1'b0;
         @(negedge clk);
         if (cyc == 3) begin
            check("bp stalled in_ready", in_ready, 0);
            check("bp stalled rf_we", rf_we, 1);
            check("bp stalled head addr", rf_waddr, bp_addr[0]);
         end
         if (rf_we && rf_ready) begin
            if (n_wr < 3) begin
               wr_addr[n_wr] = rf_waddr;
               wr_data[n_wr] = rf_wdata;
               wr_cyc[n_wr]  = cyc;
            end
            n_wr++;
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0;
      check("bp accepted count", idx, 3);
      check("bp write count", n_wr, 3);
      if (n_wr >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("bp write%0d addr", i), wr_addr[i], bp_addr[i]);
            check($sformatf("bp write%0d data", i), wr_data[i], bp_data[i]);
         end
         check("bp consecutive 0-1", wr_cyc[1] - wr_cyc[0], 1);
         check("bp consecutive 1-2", wr_cyc[2] - wr_cyc[1], 1);
      end
      check("bp flags untouched", cur_flags(), 5'b01111);

      // Flush with beats held, a head that would retire and a new beat offered.
      tick();
      rf_ready = 1'b0;
      drive_beat(16'h0d0d, 4'd4, 1'b1, 1'b1, 1'b1, 5'b10000);
      tick();
      drive_beat(16'h0e0e, 4'd6, 1'b1, 1'b1, 1'b1, 5'b11111);
      tick();
      drive_beat(16'h0f0f, 4'd8, 1'b0, 1'b1, 1'b1, 5'b00000);
      flush    = 1'b1;
      rf_ready = 1'b1;
      @(negedge clk);
      check("pre-flush rf_we", rf_we, 1);
      check("pre-flush head addr", rf_waddr, 4'd4);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush rf_we", rf_we, 0);
      check("flush rf_waddr", rf_waddr, 0);
      check("flush in_ready", in_ready, 1);
      check("flush flags", cur_flags(), 5'b01111);
      tick();
      @(negedge clk);
      check("flush drained", rf_we, 0);

      // Reset while a write to register 5 is stalled.
      tick();
      rf_ready = 1'b0;
      drive_beat(16'h5555, 4'd5, 1'b1, 1'b1, 1'b1, 5'b11111);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("pre-reset rf_we", rf_we, 1);
      check("pre-reset addr", rf_waddr, 4'd5);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("mid reset rf_we", rf_we, 0);
      check("mid reset rf_waddr", rf_waddr, 0);
      check("mid reset rf_wdata", rf_wdata, 0);
      check("mid reset flags", cur_flags(), 0);
      check("mid reset in_ready", in_ready, 1);
      rf_ready = 1'b1;
      n_wr5 = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (rf_we && rf_waddr == 4'd5) n_wr5++;
         tick();
      end
      check("no write of r5 after reset", n_wr5, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
